uart_rx_fifo: RTL

- Memory-mapped UART receiver with a receive FIFO on the PicoRV32 native memory bus, sitting beside the RAM and simpleuart decode in the SoC top.
- Deserialises 8N1 frames from the rx pin and buffers bytes in a FIFO.
- The CPU drains the FIFO through a small register window.
- Relieves the CPU from polling each byte as it arrives; overrun and framing errors are latched for software.

---
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with byte FIFO behind a 3-register PicoRV32 bus window (DIV, DATA, STATUS).
// Every access acks one cycle after acceptance; a full FIFO drops incoming bytes and latches overrun.
module uart_rx_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0010,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] DIV_RESET  = 32'd104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        sel,
    output logic        ready,
    output logic [31:0] rdata,
    input  logic        ser_rx,
    output logic        irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} rx_state_t;

    logic [31:0]           div;
    logic [31:0]           eff_div;
    logic                  sync1, rx_s;
    rx_state_t             state;
    logic [31:0]           bit_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  push_vld;
    logic                  frame_err;
    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overrun, framing;
    logic                  accept, is_read, full, empty, pop, push_ok;
    logic                  clr_ovr, clr_frm;
    logic                  unused;

    assign unused  = ^mem_addr[1:0];
    assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_addr[3:2] != 2'b11);
    assign accept  = sel && !ready;
    assign is_read = (mem_wstrb == 4'b0000);
    assign eff_div = (div < 32'd4) ? 32'd4 : div;
    assign full    = (count == DEPTH[DEPTH_LOG2:0]);
    assign empty   = (count == '0);
    assign pop     = accept && is_read && (mem_addr[3:2] == 2'b01) && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push_vld && (!full || pop);
    assign clr_ovr = accept && (mem_addr[3:2] == 2'b10) && mem_wstrb[1] && mem_wdata[8];
    assign clr_frm = accept && (mem_addr[3:2] == 2'b10) && mem_wstrb[1] && mem_wdata[9];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready <= 1'b0;
            rdata <= '0;
            div   <= DIV_RESET;
        end else begin
            ready <= accept;
            rdata <= '0;
            if (accept) begin
                case (mem_addr[3:2])
                    2'b00: begin
                        if (is_read) rdata <= div;
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i]) div[8*i +: 8] <= mem_wdata[8*i +: 8];
                    end
                    2'b01: begin
                        if (is_read)
                            rdata <= empty ? 32'hFFFF_FFFF : {23'b0, 1'b1, fifo_mem[rd_ptr]};
                    end
                    2'b10: begin
                        if (is_read)
                            rdata <= {22'b0, framing, overrun, 3'b0, 5'(count)};
                    end
                    default: rdata <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= ser_rx;
            rx_s      <= sync1;
            push_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= (eff_div >> 1) - 32'd1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 32'd1;
                    end else if (!rx_s) begin
                        bit_cnt <= eff_div - 32'd1;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 32'd1;
                    end else begin
                        shreg[bit_idx] <= rx_s;
                        bit_cnt        <= eff_div - 32'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 32'd1;
                    end else if (rx_s) begin
                        push_vld <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            framing <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)      count <= count + CNT_ONE;
            else if (!push_ok && pop) count <= count - CNT_ONE;
            if (clr_ovr)                      overrun <= 1'b0;
            else if (push_vld && full && !pop) overrun <= 1'b1;
            if (clr_frm)        framing <= 1'b0;
            else if (frame_err) framing <= 1'b1;
            irq <= !empty || overrun;
        end
    end
endmodule
